// File: rtl/ascii_pkg.sv
// Shared constants for the ASCII-art receive path: palette order, control bytes, FSM states.
package ascii_pkg;

  localparam int PALETTE_N = 48;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] FF = 8'h0C;

  typedef enum logic {ST_CLEAR, ST_RUN} dec_state_e;

  // Palette ordered dark to bright; index is the brightness level.
  function automatic logic [7:0] palette_char(input int unsigned idx);
    case (idx)
      0:  palette_char = 8'h20;  // space
      1:  palette_char = ".";
      2:  palette_char = 8'h60;  // backtick
      3:  palette_char = "-";
      4:  palette_char = ",";
      5:  palette_char = ":";
      6:  palette_char = ";";
      7:  palette_char = "~";
      8:  palette_char = "+";
      9:  palette_char = "/";
      10: palette_char = "=";
      11: palette_char = ">";
      12: palette_char = "|";
      13: palette_char = "(";
      14: palette_char = ")";
      15: palette_char = 8'h5C;  // backslash
      16: palette_char = "i";
      17: palette_char = "%";
      18: palette_char = "{";
      19: palette_char = "*";
      20: palette_char = "s";
      21: palette_char = "v";
      22: palette_char = "7";
      23: palette_char = "a";
      24: palette_char = "e";
      25: palette_char = "C";
      26: palette_char = "J";
      27: palette_char = "L";
      28: palette_char = "T";
      29: palette_char = "Y";
      30: palette_char = "w";
      31: palette_char = "F";
      32: palette_char = "9";
      33: palette_char = "V";
      34: palette_char = "G";
      35: palette_char = "X";
      36: palette_char = "A";
      37: palette_char = "E";
      38: palette_char = "$";
      39: palette_char = "&";
      40: palette_char = "#";
      41: palette_char = "@";
      42: palette_char = "R";
      43: palette_char = "W";
      44: palette_char = "0";
      45: palette_char = "N";
      46: palette_char = "M";
      47: palette_char = "Q";
      default: palette_char = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/ascii_rlut.sv
// Reverse palette lookup: maps an ASCII byte back to its brightness level.
module ascii_rlut
  import ascii_pkg::*;
(
  input  logic [7:0] char_i,
  output logic [5:0] id_o,
  output logic       hit_o
);

  always_comb begin
    id_o  = '0;
    hit_o = 1'b0;
    for (int i = 0; i < PALETTE_N; i++) begin
      if (char_i == palette_char(i)) begin
        id_o  = 6'(i);
        hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ascii_frame_decoder.sv
// Rebuilds a brightness framebuffer from an ASCII-art byte stream, clearing it on reset and on FF.
module ascii_frame_decoder
  import ascii_pkg::*;
#(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int ADDR_W = $clog2(COLS*ROWS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [5:0]        wr_level,
  output logic              frame_done,
  output logic              bad_char,
  output logic [15:0]       err_count
);

  localparam int COL_W  = $clog2(COLS + 1);
  localparam int ROW_W  = $clog2(ROWS + 1);
  // One spare bit: row_base steps to ROWS*COLS on the final LF.
  localparam int BASE_W = ADDR_W + 1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS*ROWS - 1);
  localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(COLS);
  localparam logic [ROW_W-1:0]  ROW_MAX   = ROW_W'(ROWS);
  localparam logic [BASE_W-1:0] BASE_STEP = BASE_W'(COLS);

  dec_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [BASE_W-1:0] row_base_q, row_base_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [5:0]        wr_level_q, wr_level_d;
  logic              frame_done_q, frame_done_d;
  logic              bad_char_q, bad_char_d;
  logic [15:0]       err_count_q, err_count_d;

  logic [5:0]        lut_id;
  logic              lut_hit;
  logic              accept;
  logic [COL_W-1:0]  col_inc;
  logic [BASE_W-1:0] lin_addr;

  ascii_rlut u_rlut (
    .char_i (in_data),
    .id_o   (lut_id),
    .hit_o  (lut_hit)
  );

  assign in_ready = (state_q == ST_RUN);
  assign accept   = in_valid && in_ready;
  assign col_inc  = (col_q < COL_MAX) ? col_q + 1'b1 : col_q;
  assign lin_addr = row_base_q + BASE_W'(col_q);

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    col_d        = col_q;
    row_d        = row_q;
    row_base_d   = row_base_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_level_d   = wr_level_q;
    frame_done_d = 1'b0;
    bad_char_d   = 1'b0;
    err_count_d  = err_count_q;

    case (state_q)
      ST_CLEAR: begin
        wr_en_d    = 1'b1;
        wr_addr_d  = clr_cnt_q;
        wr_level_d = '0;
        clr_cnt_d  = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d    = ST_RUN;
          clr_cnt_d  = '0;
          col_d      = '0;
          row_d      = '0;
          row_base_d = '0;
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (lut_hit) begin
            if (col_q < COL_MAX && row_q < ROW_MAX) begin
              wr_en_d    = 1'b1;
              wr_addr_d  = lin_addr[ADDR_W-1:0];
              wr_level_d = lut_id;
            end
            col_d = col_inc;
          end else if (in_data == CR) begin
            col_d = '0;
          end else if (in_data == LF) begin
            col_d = '0;
            if (row_q < ROW_MAX) begin
              row_d      = row_q + 1'b1;
              row_base_d = row_base_q + BASE_STEP;
            end
          end else if (in_data == FF) begin
            frame_done_d = 1'b1;
            state_d      = ST_CLEAR;
            clr_cnt_d    = '0;
          end else begin
            // Unknown bytes still occupy a column so the rest of the line stays aligned.
            bad_char_d = 1'b1;
            if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 1'b1;
            col_d = col_inc;
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_CLEAR;
      clr_cnt_q    <= '0;
      col_q        <= '0;
      row_q        <= '0;
      row_base_q   <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_level_q   <= '0;
      frame_done_q <= 1'b0;
      bad_char_q   <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      col_q        <= col_d;
      row_q        <= row_d;
      row_base_q   <= row_base_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_level_q   <= wr_level_d;
      frame_done_q <= frame_done_d;
      bad_char_q   <= bad_char_d;
      err_count_q  <= err_count_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_level   = wr_level_q;
  assign frame_done = frame_done_q;
  assign bad_char   = bad_char_q;
  assign err_count  = err_count_q;

endmodule
